// File: rtl/row_clear_engine.sv
// Removes a completed row from the settled board, collapsing everything above it down by one,
// and keeps line totals and per-landing burst counts for scoring.
//
// state  | meaning
// IDLE   | waiting for the scanner to report a complete row
// REMOVE | collapsed board presented with remove_valid (one unpaused cycle)
// SETTLE | ignoring the scanner while the board write-back lands
module row_clear_engine #(
    parameter int BLOCKS_WIDE   = 10,
    parameter int BLOCKS_HIGH   = 22,
    parameter int BITS_Y_POS    = 5,
    parameter int SETTLE_CYCLES = 2,
    parameter int LINES_W       = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             pause,
    input  logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] fallen_pieces,
    input  logic [BITS_Y_POS-1:0]            row,
    input  logic                             enabled,
    output logic [BLOCKS_WIDE*BLOCKS_HIGH-1:0] board_out,
    output logic                             remove_valid,
    output logic                             busy,
    output logic [LINES_W-1:0]               lines_total,
    output logic [2:0]                       burst_lines,
    output logic                             burst_done
);
    localparam int BOARD_W = BLOCKS_WIDE * BLOCKS_HIGH;
    localparam int SC_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int QW      = $clog2(BLOCKS_HIGH + 1);
    localparam logic [QW-1:0] QUIET_MAX = QW'(BLOCKS_HIGH);
    localparam logic [BITS_Y_POS:0] ROW_LIMIT = (BITS_Y_POS + 1)'(BLOCKS_HIGH);

    typedef enum logic [1:0] {IDLE, REMOVE, SETTLE} state_t;

    state_t                  state, state_nxt;
    logic [BITS_Y_POS-1:0]   clr_row;
    logic [BOARD_W-1:0]      snap;
    logic [SC_W-1:0]         settle_cnt;
    logic [QW-1:0]           quiet_cnt;
    logic [2:0]              burst_cnt;
    logic [2:0]              burst_lines_q;
    logic                    detect;
    logic                    burst_end;

    assign detect = !pause && (state == IDLE) && enabled && ({1'b0, row} < ROW_LIMIT);

    always_comb begin
        state_nxt    = state;
        remove_valid = 1'b0;
        burst_end    = 1'b0;
        case (state)
            IDLE: begin
                if (detect)
                    state_nxt = REMOVE;
                else if (!pause && burst_cnt != 3'd0 && quiet_cnt == QUIET_MAX)
                    burst_end = 1'b1;
            end
            REMOVE: begin
                if (!pause) begin
                    remove_valid = 1'b1;
                    state_nxt    = SETTLE;
                end
            end
            SETTLE: begin
                if (!pause && settle_cnt == '0)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy        = (state != IDLE);
    assign burst_done  = burst_end;
    assign burst_lines = burst_end ? burst_cnt : burst_lines_q;

    // Collapsed board is a pure function of the snapshot, so it holds until the next detection.
    always_comb begin
        board_out = snap;
        board_out[0 +: BLOCKS_WIDE] = '0;
        for (int r = 1; r < BLOCKS_HIGH; r++) begin
            if (r <= int'(clr_row))
                board_out[r*BLOCKS_WIDE +: BLOCKS_WIDE] = snap[(r-1)*BLOCKS_WIDE +: BLOCKS_WIDE];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            clr_row       <= '0;
            snap          <= '0;
            settle_cnt    <= '0;
            quiet_cnt     <= '0;
            burst_cnt     <= '0;
            burst_lines_q <= '0;
            lines_total   <= '0;
        end else begin
            state <= state_nxt;
            if (detect) begin
                clr_row <= row;
                snap    <= fallen_pieces;
            end
            if (remove_valid) begin
                if (lines_total != '1)
                    lines_total <= lines_total + 1'b1;
                if (burst_cnt != 3'd4)
                    burst_cnt <= burst_cnt + 3'd1;
                quiet_cnt  <= '0;
                settle_cnt <= SC_W'(SETTLE_CYCLES - 1);
            end
            if (state == SETTLE && !pause && settle_cnt != '0)
                settle_cnt <= settle_cnt - 1'b1;
            if (burst_end) begin
                burst_lines_q <= burst_cnt;
                burst_cnt     <= '0;
                quiet_cnt     <= '0;
            end else if (state == IDLE && !pause && !detect && burst_cnt != 3'd0) begin
                quiet_cnt <= quiet_cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/row_clear_engine.md
Name: row_clear_engine

Overview:
- Sits directly downstream of the complete-row scanner. Consumes its `row` / `enabled` pair plus the settled-pieces bitmap.
- When a full row is reported, it produces the collapsed board: the full row is removed, all rows above drop by one, and the top row is refilled empty. It presents this board to the board-state owner with a one-cycle write strobe.
- Also tracks total lines cleared and groups clears into "bursts" (lines cleared by one piece landing) for the scoring logic.

Parameters:
- BLOCKS_WIDE, 10, columns per row.
- BLOCKS_HIGH, 22, rows on the board. Row 0 is the top; row r occupies bits [r*BLOCKS_WIDE +: BLOCKS_WIDE].
- BITS_Y_POS, 5, width of a row index.
- SETTLE_CYCLES, 2, cycles `enabled` is ignored after a write strobe, to cover board write-back latency.
- LINES_W, 16, width of the total-lines counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- pause  in  1  freezes all state and counters while high.
- fallen_pieces  in  BLOCKS_WIDE*BLOCKS_HIGH  current settled board.
- row  in  BITS_Y_POS  row index under test by the scanner.
- enabled  in  1  high when `row` is complete.
- board_out  out  BLOCKS_WIDE*BLOCKS_HIGH  collapsed board, valid while remove_valid is high.
- remove_valid  out  1  one-cycle strobe; the consumer loads board_out into fallen_pieces on this edge.
- busy  out  1  high in REMOVE and SETTLE.
- lines_total  out  LINES_W  saturating count of rows cleared.
- burst_lines  out  3  line count of the last finished burst (0..4).
- burst_done  out  1  one-cycle strobe when a burst ends; burst_lines is valid with it.

Behaviour:
- Reset: asynchronous, active-high. All outputs are 0, board_out is all zeros, FSM is in IDLE, internal counters are 0.
- pause high: FSM, counters and strobes hold. Strobes are forced low and do not re-fire after unpause.
- FSM states and transitions:
  - IDLE: if enabled && row < BLOCKS_HIGH, latch row into clr_row and the board into a snapshot register, then go to REMOVE.
  - REMOVE (exactly 1 cycle):
    - Assert remove_valid.
    - board_out row r = snapshot row r-1 for 1 <= r <= clr_row.
    - board_out row 0 = all zeros.
    - board_out row r = snapshot row r for r > clr_row.
    - Increment lines_total (saturate at all-ones) and burst_cnt (saturate at 4). Clear quiet_cnt. Go to SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles, ignoring enabled, then return to IDLE.
- Latency: enabled sampled at edge N gives remove_valid high for cycle N+1. The earliest next detection is at edge N+2+SETTLE_CYCLES.
- board_out holds its last value outside REMOVE. Only remove_valid qualifies it.
- Burst tracking:
  - quiet_cnt increments each unpaused cycle in IDLE while burst_cnt > 0.
  - When quiet_cnt reaches BLOCKS_HIGH, pulse burst_done for 1 cycle with burst_lines = burst_cnt, then clear burst_cnt and quiet_cnt.
  - If a new detection occurs on that same cycle, the detection wins: burst continues, no burst_done.
- clr_row = 0: board_out row 0 = zeros and all other rows are unchanged.
- clr_row = BLOCKS_HIGH-1: the whole board shifts down by one.
- row values >= BLOCKS_HIGH are ignored.
- Reset mid-REMOVE or mid-SETTLE: return to IDLE immediately with no strobe; lines_total is cleared.

Test Plan:
- Empty board, enabled held low for 100 cycles -> remove_valid, burst_done never assert; lines_total = 0.
- Row 21 full, row 20 = 10'b1010101010, enabled pulsed with row=21 -> remove_valid 1 cycle later; board_out row 21 = 10'b1010101010, row 0 = 0; lines_total = 1.
- Rows 20 and 21 full, scanner model writes back board_out on strobe -> two strobes ≥ 4 cycles apart; 22 quiet cycles after the second, burst_done with burst_lines = 2.
- enabled held high continuously during SETTLE -> no second strobe before SETTLE_CYCLES elapse.
- pause asserted the cycle after detection for 5 cycles -> remove_valid appears only after pause falls; counters frozen throughout.
- lines_total preloaded near 16'hFFFF via repeated clears -> saturates at 16'hFFFF. rst asserted mid-SETTLE -> all outputs 0 asynchronously.
